// File: rtl/jtsdram_pkg.sv
// Shared definitions for the SDRAM bank fill/check slice: FSM state
// encoding, the pattern LFSR taps and the default pattern seed.
package jtsdram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Feedback taps: bits 15, 13, 12 and 10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Default pattern after reset (must be non-zero)
  localparam logic [15:0] SEED_DEF = 16'hA5C3;

  // One raw LFSR step, without any zero-state handling
  function automatic logic [15:0] lfsr_step(input logic [15:0] d);
    return {d[14:0], ^(d & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/jtsdram_lfsr16.sv
// Combinational next-pattern function for the 16-bit fill pattern.
// The all-zero state would lock the LFSR, so it is replaced by 1.
module jtsdram_lfsr16
  import jtsdram_pkg::*;
(
  input  logic [15:0] din,
  output logic [15:0] dout
);

  logic [15:0] step_s;

  assign step_s = lfsr_step(din);

  // Next pattern with the zero-lockout escape
  always_comb begin
    dout = step_s;
    if (step_s == 16'h0000) begin
      dout = 16'h0001;
    end else begin
      dout = step_s;
    end
  end

endmodule

// File: rtl/jtsdram_bank_fill.sv
// Fills one SDRAM bank with the constant word {2{data_ref}}, one address
// per wr/ack/rdy handshake. data_ref only moves on an accepted start so the
// downstream checker can compare against it after the pass has finished.
module jtsdram_bank_fill
  import jtsdram_pkg::*;
#(
  parameter int          AW   = 22,
  parameter logic [15:0] SEED = SEED_DEF,
  parameter int          TOUT = 255
)(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          pat_ld,
  input  logic [15:0]   pat_in,
  output logic [AW-1:0] addr,
  output logic          wr,
  input  logic          ack,
  input  logic          rdy,
  output logic [31:0]   data_write,
  output logic [15:0]   data_ref,
  output logic          busy,
  output logic          done,
  output logic          tout_err
);

  // Counter value at which one more stalled cycle means the timeout is reached
  localparam logic [7:0]    TOUT_LAST = 8'(TOUT - 1);
  localparam logic [AW-1:0] ADDR_ONE  = AW'(1);

  state_t      state_r;
  logic [7:0]  wait_cnt_r;
  logic [15:0] lfsr_next_s;
  logic        last_s;
  logic        tout_hit_s;

  jtsdram_lfsr16 u_lfsr (
    .din  (data_ref),
    .dout (lfsr_next_s)
  );

  assign data_write = {2{data_ref}};
  assign last_s     = &addr;
  assign tout_hit_s = (wait_cnt_r == TOUT_LAST);

  // Fill sequencer: start/handshake/timeout FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      addr       <= '0;
      wr         <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      tout_err   <= 1'b0;
      data_ref   <= SEED;
      wait_cnt_r <= 8'd0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            data_ref   <= pat_ld ? pat_in : lfsr_next_s;
            addr       <= '0;
            wr         <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
            tout_err   <= 1'b0;
            wait_cnt_r <= 8'd0;
            state_r    <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (ack && rdy) begin
            // Accept and completion together: skip WAIT entirely
            wait_cnt_r <= 8'd0;
            if (last_s) begin
              wr      <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
              state_r <= ST_DONE;
            end else begin
              addr    <= addr + ADDR_ONE;
              wr      <= 1'b1;
              state_r <= ST_REQ;
            end
          end else if (ack) begin
            wr         <= 1'b0;
            wait_cnt_r <= 8'd0;
            state_r    <= ST_WAIT;
          end else if (tout_hit_s) begin
            wr         <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
            tout_err   <= 1'b1;
            wait_cnt_r <= 8'd0;
            state_r    <= ST_DONE;
          end else begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
          end
        end
        ST_WAIT: begin
          if (rdy) begin
            wait_cnt_r <= 8'd0;
            if (last_s) begin
              wr      <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
              state_r <= ST_DONE;
            end else begin
              addr    <= addr + ADDR_ONE;
              wr      <= 1'b1;
              state_r <= ST_REQ;
            end
          end else if (tout_hit_s) begin
            wr         <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
            tout_err   <= 1'b1;
            wait_cnt_r <= 8'd0;
            state_r    <= ST_DONE;
          end else begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
          end
        end
        default: begin
          wr         <= 1'b0;
          busy       <= 1'b0;
          wait_cnt_r <= 8'd0;
          state_r    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtsdram_bank_fill.sv
// Scoreboard bench for jtsdram_bank_fill (AW=3, TOUT=16). A controller model
// answers the handshake; the stimulus side pushes expected writes and pass
// outcomes, and a monitor pops and compares them as the DUT produces them.
module tb_jtsdram_bank_fill;

  localparam int          AW   = 3;
  localparam int          TOUT = 16;
  localparam logic [15:0] SEED = 16'hA5C3;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          pat_ld;
  logic [15:0]   pat_in;
  logic [AW-1:0] addr;
  logic          wr;
  logic          ack;
  logic          rdy;
  logic [31:0]   data_write;
  logic [15:0]   data_ref;
  logic          busy;
  logic          done;
  logic          tout_err;

  jtsdram_bank_fill #(.AW(AW), .SEED(SEED), .TOUT(TOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .pat_ld     (pat_ld),
    .pat_in     (pat_in),
    .addr       (addr),
    .wr         (wr),
    .ack        (ack),
    .rdy        (rdy),
    .data_write (data_write),
    .data_ref   (data_ref),
    .busy       (busy),
    .done       (done),
    .tout_err   (tout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          a;
    logic [31:0] d;
  } wr_exp_t;

  typedef struct {
    int          a;
    logic        te;
    logic [15:0] r;
    int          dlt;
  } end_exp_t;

  wr_exp_t  wq[$];
  end_exp_t eq[$];

  int n_checks = 0;
  int n_pass   = 0;

  // controller behaviour: 0 = ack after 1 cycle, rdy after 3; 1 = ack+rdy together after 2
  int mode       = 0;
  int stall_en   = 0;
  int stall_addr = 0;

  logic [15:0] m_ref;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  // Reference pattern step: shift left, feedback = parity of tapped bits, never zero
  function automatic logic [15:0] model_next(input logic [15:0] d);
    int fb;
    int r;
    fb = $countones(d & 16'hB400) % 2;
    r  = (int'(d) * 2 + fb) % 65536;
    if (r == 0) r = 1;
    return 16'(r);
  endfunction

  // SDRAM controller model
  initial begin
    int ph;
    ph  = 0;
    ack = 1'b0;
    rdy = 1'b0;
    forever begin
      @(negedge clk);
      ack = 1'b0;
      rdy = 1'b0;
      if (!rst_n) begin
        ph = 0;
      end else if (wr || ph > 0) begin
        ph++;
        if (mode == 1) begin
          if (ph == 2) begin
            ack = 1'b1;
            rdy = 1'b1;
            ph  = 0;
          end
        end else begin
          if (ph == 1) ack = 1'b1;
          if (ph == 3) begin
            if (!(stall_en != 0 && int'(addr) == stall_addr)) rdy = 1'b1;
            ph = 0;
          end
        end
      end
    end
  end

  // Monitor: compares accepted writes and pass outcomes against the scoreboard
  initial begin
    int   msamp;
    int   last_ack;
    logic done_q;
    wr_exp_t  w;
    end_exp_t e;
    msamp    = 0;
    last_ack = 0;
    done_q   = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      msamp++;
      if (rst_n) begin
        if (wr && ack) begin
          last_ack = msamp;
          chk("write_expected", 32'(wq.size() != 0), 32'd1);
          if (wq.size() != 0) begin
            w = wq.pop_front();
            chk("write_addr", 32'(addr), 32'(w.a));
            chk("write_data", data_write, w.d);
          end
        end
        if (done && !done_q) begin
          chk("done_expected", 32'(eq.size() != 0), 32'd1);
          if (eq.size() != 0) begin
            e = eq.pop_front();
            chk("done_addr", 32'(addr), 32'(e.a));
            chk("done_tout_err", 32'(tout_err), 32'(e.te));
            chk("done_busy", 32'(busy), 32'd0);
            chk("done_wr", 32'(wr), 32'd0);
            chk("done_data_ref", 32'(data_ref), 32'(e.r));
            if (e.dlt >= 0) chk("timeout_latency", 32'(msamp - last_ack), 32'(e.dlt));
          end
        end
      end
      done_q = done;
    end
  end

  task automatic push_pass(input logic ld, input logic [15:0] pin, input int stall_at);
    int last;
    m_ref = ld ? pin : model_next(m_ref);
    last  = (stall_at >= 0) ? stall_at : (1 << AW) - 1;
    for (int a = 0; a <= last; a++) wq.push_back('{a, {m_ref, m_ref}});
    eq.push_back('{last, stall_at >= 0, m_ref, (stall_at >= 0) ? TOUT + 1 : -1});
  endtask

  task automatic issue_start(input logic ld, input logic [15:0] pin);
    @(negedge clk); #1;
    start  = 1'b1;
    pat_ld = ld;
    pat_in = pin;
    @(negedge clk); #1;
    start  = 1'b0;
    pat_ld = 1'($urandom);
    pat_in = 16'($urandom);
    chk("start_wr", 32'(wr), 32'd1);
    chk("start_addr", 32'(addr), 32'd0);
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_done", 32'(done), 32'd0);
    chk("start_tout_err", 32'(tout_err), 32'd0);
    chk("start_data_ref", 32'(data_ref), 32'(m_ref));
    chk("start_data_write", data_write, {m_ref, m_ref});
  endtask

  task automatic run_pass(input logic ld, input logic [15:0] pin, input int md,
                          input int stall_at, input int inj_at, input int exp_cyc);
    int cyc;
    bit fin;
    bit inj;
    bit inj_chk;
    mode       = md;
    stall_en   = (stall_at >= 0) ? 1 : 0;
    stall_addr = stall_at;
    push_pass(ld, pin, stall_at);
    issue_start(ld, pin);
    cyc     = 0;
    fin     = 1'b0;
    inj     = 1'b0;
    inj_chk = 1'b0;
    if (done) fin = 1'b1;
    for (int i = 0; i < 200 && !fin; i++) begin
      if (start) start = 1'b0;
      if (inj_at >= 0 && !inj && busy && int'(addr) == inj_at) begin
        start  = 1'b1;
        pat_ld = 1'($urandom);
        pat_in = 16'($urandom);
        inj    = 1'b1;
      end
      @(negedge clk); #1;
      cyc++;
      if (inj && !inj_chk) begin
        chk("ignored_start_ref", 32'(data_ref), 32'(m_ref));
        chk("ignored_start_busy", 32'(busy), 32'd1);
        inj_chk = 1'b1;
      end
      if (done) fin = 1'b1;
    end
    start = 1'b0;
    chk("pass_finished", 32'(fin), 32'd1);
    if (exp_cyc >= 0) chk("pass_cycles", 32'(cyc), 32'(exp_cyc));
    #3;
    chk("writes_left", 32'(wq.size()), 32'd0);
    chk("outcomes_left", 32'(eq.size()), 32'd0);
    wq.delete();
    eq.delete();
    stall_en = 0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_addr"}, 32'(addr), 32'd0);
    chk({tag, "_wr"}, 32'(wr), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_tout_err"}, 32'(tout_err), 32'd0);
    chk({tag, "_data_ref"}, 32'(data_ref), 32'(SEED));
    chk({tag, "_data_write"}, data_write, {SEED, SEED});
  endtask

  initial begin
    int md;
    int st;
    int inj;
    int ec;
    bit hit;
    rst_n  = 1'b0;
    start  = 1'b0;
    pat_ld = 1'b0;
    pat_in = 16'h0000;
    m_ref  = SEED;
    repeat (3) @(negedge clk);
    #1;
    check_reset_state("reset");
    rst_n = 1'b1;

    // Plain pass from the seed
    run_pass(1'b0, 16'h0000, 0, -1, -1, 24);
    // Explicit all-zero pattern, then the LFSR must escape zero
    run_pass(1'b1, 16'h0000, 0, -1, -1, 24);
    run_pass(1'b0, 16'h0000, 0, -1, -1, 24);
    chk("zero_escape_ref", 32'(data_ref), 32'h0000_0001);
    // ack and rdy together
    run_pass(1'b1, 16'h1234, 1, -1, -1, 16);
    // rdy withheld at address 5, then a clean pass clears tout_err
    run_pass(1'b0, 16'h0000, 0, 5, -1, -1);
    run_pass(1'b0, 16'h0000, 0, -1, -1, 24);
    // start pulsed while busy at address 3
    run_pass(1'b1, 16'hBEEF, 0, -1, 3, 24);

    // Randomized passes
    for (int k = 0; k < 10; k++) begin
      md  = $urandom_range(0, 1);
      st  = (md == 0 && $urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : -1;
      inj = (st < 0 && $urandom_range(0, 1) == 1) ? $urandom_range(1, 6) : -1;
      ec  = (st >= 0) ? -1 : ((md == 1) ? 16 : 24);
      run_pass(1'($urandom), 16'($urandom), md, st, inj, ec);
    end

    // Reset asserted mid-pass at address 2
    mode     = 0;
    stall_en = 0;
    push_pass(1'b0, 16'h0000, -1);
    issue_start(1'b0, 16'h0000);
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      if (addr == 3'd2) hit = 1'b1;
      else begin
        @(negedge clk); #1;
      end
    end
    chk("reached_addr2", 32'(hit), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_state("midpass_reset");
    wq.delete();
    eq.delete();
    m_ref = SEED;
    @(negedge clk); #1;
    rst_n = 1'b1;
    run_pass(1'b0, 16'h0000, 0, -1, -1, 24);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
